// File: rtl/pe_output_drain_pkg.sv
// Shared accelerator definitions for the PE-array output drain: array
// geometry and the drain FSM state encoding.
package pe_output_drain_pkg;

  localparam int PE_ROWS = 16;
  localparam int PE_COLS = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

endpackage : pe_output_drain_pkg

// File: rtl/pe_output_drain_requant_sat.sv
// One requantization lane: round-half-up, arithmetic right shift, optional
// ReLU, then saturation into the signed activation range. Purely combinational.
module requant_sat #(
  parameter int OUTPUT_WIDTH = 32,
  parameter int ACT_WIDTH    = 8
) (
  input  logic signed [OUTPUT_WIDTH-1:0] din,
  input  logic        [4:0]              shift,
  input  logic                           relu_en,
  output logic signed [ACT_WIDTH-1:0]    dout
);

  // Saturation bounds expressed at the widened (OUTPUT_WIDTH+1) precision.
  localparam logic signed [OUTPUT_WIDTH:0] SAT_MAX =
    {{(OUTPUT_WIDTH-ACT_WIDTH+2){1'b0}}, {(ACT_WIDTH-1){1'b1}}};
  localparam logic signed [OUTPUT_WIDTH:0] SAT_MIN = ~SAT_MAX;

  // The extra headroom bit keeps the rounding bias from overflowing.
  function automatic logic signed [OUTPUT_WIDTH:0] round_shift(
    input logic signed [OUTPUT_WIDTH-1:0] v,
    input logic        [4:0]              sh
  );
    logic signed [OUTPUT_WIDTH:0] ext;
    logic signed [OUTPUT_WIDTH:0] bias;
    ext  = {v[OUTPUT_WIDTH-1], v};
    bias = '0;
    if (sh != 5'd0) begin
      bias = {{OUTPUT_WIDTH{1'b0}}, 1'b1} <<< (sh - 5'd1);
    end
    return (ext + bias) >>> sh;
  endfunction

  function automatic logic signed [ACT_WIDTH-1:0] relu_saturate(
    input logic signed [OUTPUT_WIDTH:0] v,
    input logic                         relu
  );
    logic signed [OUTPUT_WIDTH:0] r;
    r = v;
    if (relu && (r < 0)) begin
      r = '0;
    end
    if (r > SAT_MAX) begin
      return SAT_MAX[ACT_WIDTH-1:0];
    end else if (r < SAT_MIN) begin
      return SAT_MIN[ACT_WIDTH-1:0];
    end
    return r[ACT_WIDTH-1:0];
  endfunction

  // Combinational lane result.
  always_comb begin
    dout = relu_saturate(round_shift(din, shift), relu_en);
  end

endmodule : requant_sat

// File: rtl/pe_output_drain.sv
// Captures a full 16x16 PE-array result tile in one cycle, then streams it out
// one requantized row per valid/ready beat, rows 0..15, before accepting the
// next tile.
module pe_output_drain
  import pe_output_drain_pkg::*;
#(
  parameter int OUTPUT_WIDTH = 32,
  parameter int ACT_WIDTH    = 8
) (
  input  logic                           clk,
  input  logic                           arst_n_in,
  input  logic                           capture_valid,
  output logic                           capture_ready,
  input  logic signed [OUTPUT_WIDTH-1:0] pe_outs [0:PE_ROWS-1][0:PE_COLS-1],
  input  logic        [4:0]              shift,
  input  logic                           relu_en,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [ACT_WIDTH-1:0]    out_row [0:PE_COLS-1],
  output logic        [3:0]              out_row_idx,
  output logic                           out_last
);

  drain_state_e state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic         out_valid_q, out_valid_d;
  logic         out_last_q, out_last_d;
  logic         capture_ready_q, capture_ready_d;

  logic signed [OUTPUT_WIDTH-1:0] buf_q [0:PE_ROWS-1][0:PE_COLS-1];
  logic signed [OUTPUT_WIDTH-1:0] buf_d [0:PE_ROWS-1][0:PE_COLS-1];
  logic [4:0] shift_q, shift_d;
  logic       relu_q, relu_d;

  logic capture_fire;
  logic beat_fire;
  logic signed [ACT_WIDTH-1:0] lane_res [0:PE_COLS-1];

  assign capture_fire = capture_valid && capture_ready_q;
  assign beat_fire    = out_valid_q && out_ready;

  // Tile buffer and requant settings load only on an accepted capture.
  always_comb begin
    buf_d   = buf_q;
    shift_d = shift_q;
    relu_d  = relu_q;
    if (capture_fire) begin
      buf_d   = pe_outs;
      shift_d = shift;
      relu_d  = relu_en;
    end
  end

  // Drain FSM next state; outputs are computed here so they leave as flops.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    out_valid_d     = out_valid_q;
    out_last_d      = out_last_q;
    capture_ready_d = capture_ready_q;
    case (state_q)
      IDLE: begin
        if (capture_fire) begin
          state_d         = DRAIN;
          idx_d           = '0;
          out_valid_d     = 1'b1;
          out_last_d      = 1'b0;
          capture_ready_d = 1'b0;
        end
      end
      DRAIN: begin
        if (beat_fire) begin
          if (idx_q == 4'(PE_ROWS-1)) begin
            state_d         = IDLE;
            idx_d           = '0;
            out_valid_d     = 1'b0;
            out_last_d      = 1'b0;
            capture_ready_d = 1'b1;
          end else begin
            idx_d      = idx_q + 4'd1;
            out_last_d = (idx_q == 4'(PE_ROWS-2));
          end
        end
      end
    endcase
  end

  // Control state with asynchronous reset; reset aborts any drain.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      out_valid_q     <= 1'b0;
      out_last_q      <= 1'b0;
      capture_ready_q <= 1'b1;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      out_valid_q     <= out_valid_d;
      out_last_q      <= out_last_d;
      capture_ready_q <= capture_ready_d;
    end
  end

  // Data storage is never read before a capture writes it, so no reset.
  always_ff @(posedge clk) begin
    buf_q   <= buf_d;
    shift_q <= shift_d;
    relu_q  <= relu_d;
  end

  for (genvar c = 0; c < PE_COLS; c++) begin : g_lane
    requant_sat #(
      .OUTPUT_WIDTH (OUTPUT_WIDTH),
      .ACT_WIDTH    (ACT_WIDTH)
    ) u_requant_sat (
      .din     (buf_q[idx_q][c]),
      .shift   (shift_q),
      .relu_en (relu_q),
      .dout    (lane_res[c])
    );
    // Lanes read as zero whenever no beat is presented.
    assign out_row[c] = out_valid_q ? lane_res[c] : '0;
  end

  assign capture_ready = capture_ready_q;
  assign out_valid     = out_valid_q;
  assign out_last      = out_last_q;
  assign out_row_idx   = idx_q;

endmodule : pe_output_drain

// File: tb/tb_pe_output_drain.sv
// Directed and randomized bench for pe_output_drain with a reference model
// computed from the requantization rules in wide integer arithmetic.
module tb_pe_output_drain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              arst_n_in;
  logic              capture_valid;
  logic              capture_ready;
  logic signed [31:0] pe_outs [0:15][0:15];
  logic [4:0]        shift;
  logic              relu_en;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] out_row [0:15];
  logic [3:0]        out_row_idx;
  logic              out_last;

  pe_output_drain #(
    .OUTPUT_WIDTH (32),
    .ACT_WIDTH    (8)
  ) dut (
    .clk           (clk),
    .arst_n_in     (arst_n_in),
    .capture_valid (capture_valid),
    .capture_ready (capture_ready),
    .pe_outs       (pe_outs),
    .shift         (shift),
    .relu_en       (relu_en),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_row       (out_row),
    .out_row_idx   (out_row_idx),
    .out_last      (out_last)
  );

  int checks = 0;
  int errors = 0;
  int cap_mat [16][16];
  int cap_sh;
  bit cap_relu;

  function automatic int model_lane(input int v, input int sh, input bit relu);
    longint t;
    t = v;
    if (sh > 0) t = t + (longint'(1) << (sh - 1));
    t = t >>> sh;
    if (relu && t < 0) t = 0;
    if (t > 127) t = 127;
    if (t < -128) t = -128;
    return int'(t);
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_random(input int kind);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        if (kind == 0) pe_outs[r][c] = int'($urandom);
        else           pe_outs[r][c] = int'($urandom_range(1200)) - 600;
  endtask

  task automatic do_capture(input int sh, input bit relu);
    shift         = 5'(sh);
    relu_en       = relu;
    capture_valid = 1'b1;
    chk("capture_ready_idle", capture_ready, 1);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        cap_mat[r][c] = pe_outs[r][c];
    cap_sh   = sh;
    cap_relu = relu;
    @(posedge clk); #1;
    capture_valid = 1'b0;
    shift         = 5'($urandom);
    relu_en       = 1'($urandom);
  endtask

  // mode 0: ready always; 1: ready pattern 1,0,0,1 plus ignored capture pulse;
  // 2: random ready. abort_row >= 0 asserts reset while that row is presented.
  task automatic drain(input int mode, input int abort_row);
    int row;
    int cyc;
    bit rdy;
    bit held;
    int prev_idx;
    logic signed [7:0] prev [16];
    row  = 0;
    cyc  = 0;
    held = 1'b0;
    prev_idx = 0;
    while (row < 16 && cyc < 200) begin
      chk($sformatf("valid r%0d", row), out_valid, 1);
      chk($sformatf("cap_ready_busy r%0d", row), capture_ready, 0);
      chk($sformatf("idx r%0d", row), out_row_idx, row);
      chk($sformatf("last r%0d", row), out_last, (row == 15));
      for (int c = 0; c < 16; c++)
        chk($sformatf("lane r%0d c%0d", row, c), out_row[c],
            model_lane(cap_mat[row][c], cap_sh, cap_relu));
      if (held) begin
        chk($sformatf("hold_idx r%0d", row), out_row_idx, prev_idx);
        for (int c = 0; c < 16; c++)
          chk($sformatf("hold_lane r%0d c%0d", row, c), out_row[c], prev[c]);
      end
      if (row == abort_row) begin
        arst_n_in = 1'b0;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_cap_ready", capture_ready, 1);
        chk("abort_last", out_last, 0);
        chk("abort_idx", out_row_idx, 0);
        chk("abort_lane0", out_row[0], 0);
        @(posedge clk); #1;
        arst_n_in = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk("post_abort_valid", out_valid, 0);
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: rdy = 1'($urandom);
      endcase
      if (mode == 1 && cyc == 2) begin
        fill_random(0);
        capture_valid = 1'b1;
      end
      prev_idx = out_row_idx;
      for (int c = 0; c < 16; c++) prev[c] = out_row[c];
      held      = !rdy;
      out_ready = rdy;
      @(posedge clk); #1;
      capture_valid = 1'b0;
      if (rdy) row++;
      cyc++;
    end
    out_ready = 1'b0;
    if (row < 16) begin
      chk("drain_timeout", row, 16);
    end else begin
      chk("end_valid", out_valid, 0);
      chk("end_cap_ready", capture_ready, 1);
      chk("end_last", out_last, 0);
      chk("end_lane0", out_row[0], 0);
      @(posedge clk); #1;
      chk("end_valid_stays_low", out_valid, 0);
    end
  endtask

  initial begin
    int exp_rs [5];
    int exp_relu [4];
    exp_rs   = '{1, 2, -1, 127, -128};
    exp_relu = '{0, 0, 0, 50};

    arst_n_in     = 1'b0;
    capture_valid = 1'b0;
    out_ready     = 1'b0;
    shift         = '0;
    relu_en       = 1'b0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        pe_outs[r][c] = 0;

    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_cap_ready", capture_ready, 1);
    chk("rst_last", out_last, 0);
    chk("rst_idx", out_row_idx, 0);
    chk("rst_lane0", out_row[0], 0);
    @(posedge clk); #1;
    arst_n_in = 1'b1;
    @(posedge clk); #1;
    chk("idle_valid", out_valid, 0);

    // Basic drain with an index ramp
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        pe_outs[r][c] = r * 16 + c;
    do_capture(0, 1'b0);
    drain(0, -1);

    // Rounding and saturation
    fill_random(0);
    for (int r = 0; r < 16; r++) begin
      pe_outs[r][0] = 5;
      pe_outs[r][1] = 6;
      pe_outs[r][2] = -6;
      pe_outs[r][3] = 100000;
      pe_outs[r][4] = -100000;
    end
    do_capture(2, 1'b0);
    for (int c = 0; c < 5; c++)
      chk($sformatf("round_sat c%0d", c), out_row[c], exp_rs[c]);
    drain(0, -1);

    // ReLU
    fill_random(1);
    for (int r = 0; r < 16; r++) begin
      pe_outs[r][0] = -1;
      pe_outs[r][1] = -300;
      pe_outs[r][2] = 0;
      pe_outs[r][3] = 50;
    end
    do_capture(0, 1'b1);
    for (int c = 0; c < 4; c++)
      chk($sformatf("relu c%0d", c), out_row[c], exp_relu[c]);
    drain(0, -1);

    // Backpressure with an ignored mid-drain capture
    fill_random(1);
    do_capture(1, 1'b0);
    drain(1, -1);

    // Randomized tiles, settings and ready
    for (int i = 0; i < 6; i++) begin
      fill_random(i % 2);
      do_capture(int'($urandom_range(31)), 1'($urandom));
      drain(2, -1);
    end

    // Reset mid-drain, then a fresh capture restarts at row 0
    fill_random(1);
    do_capture(0, 1'b0);
    drain(0, 7);
    fill_random(0);
    do_capture(20, 1'b1);
    drain(0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pe_output_drain

// File: doc/pe_output_drain.md
PE_OUTPUT_DRAIN -- requirements
Module: pe_output_drain

Interface
REQ-001 SHALL have parameter OUTPUT_WIDTH, default 32, the signed width of each captured PE-array result.
REQ-002 SHALL have parameter ACT_WIDTH, default 8, the signed width of each requantized output lane.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 SHALL have port arst_n_in, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-005 SHALL have port capture_valid, input, 1 bit; the PE-array results are final and may be captured.
REQ-006 SHALL have port capture_ready, output, 1 bit; the block can accept a capture.
REQ-007 SHALL have port pe_outs, input, signed [OUTPUT_WIDTH-1:0] [0:15][0:15]; the PE-array results, indexed [row][col].
REQ-008 SHALL have port shift, input, 5 bits; the right-shift amount, sampled at capture.
REQ-009 SHALL have port relu_en, input, 1 bit; enables ReLU, sampled at capture.
REQ-010 SHALL have port out_valid, output, 1 bit; out_row holds a valid beat.
REQ-011 SHALL have port out_ready, input, 1 bit; the downstream consumer accepts the beat.
REQ-012 SHALL have port out_row, output, signed [ACT_WIDTH-1:0] [0:15]; one requantized row.
REQ-013 SHALL have port out_row_idx, output, 4 bits; the row index of the current beat.
REQ-014 SHALL have port out_last, output, 1 bit; high together with out_valid on row 15.

Function
REQ-015 SHALL implement an FSM with two states: IDLE and DRAIN.
REQ-016 SHALL drive capture_ready high only in IDLE.
REQ-017 SHALL, on a cycle with capture_valid && capture_ready, register all 256 pe_outs words plus shift and relu_en, set row index to 0, and enter DRAIN.
REQ-018 SHALL, in DRAIN, drive out_valid = 1, with out_row derived from the buffered row[idx]; the first beat is valid the cycle after capture (1-cycle latency).
REQ-019 SHALL increment idx on each out_valid && out_ready cycle.
REQ-020 SHALL, on a handshake with idx = 15, return to IDLE; out_valid is 0 the next cycle, and there is no wrap to row 0.
REQ-021 SHALL hold out_row, out_row_idx and out_last stable while out_valid && !out_ready.
REQ-022 SHALL ignore capture_valid during DRAIN; the buffer is never overwritten mid-drain.
REQ-023 SHALL requantize each lane as follows: sign-extend to OUTPUT_WIDTH+1 bits; if shift > 0, add 2^(shift-1); then arithmetic right shift by shift.
REQ-024 SHALL apply ReLU when relu_en = 1: negative results become 0.
REQ-025 SHALL saturate each lane to [-2^(ACT_WIDTH-1), 2^(ACT_WIDTH-1)-1]; with the default, this is [-128, 127].
REQ-026 SHALL treat shift = 0 as pass-through followed by saturation; the rounding add does not overflow, thanks to the extra bit.
REQ-027 SHALL hold out_row at 0 whenever out_valid = 0.

Reset
REQ-028 SHALL, on arst_n_in low, force state = IDLE, idx = 0, out_valid = 0, out_last = 0, out_row_idx = 0, out_row = all 0, and capture_ready = 1, regardless of the clock.
REQ-029 SHALL abort any drain in progress on reset; no further beats are emitted until a new capture.
REQ-030 SHALL leave the 256-word capture buffer, shift register and relu register un-reset; they are always written before use.

Structure
REQ-031 SHALL place in the shared accelerator package: the FSM state enum (IDLE, DRAIN) and the constants PE_ROWS = 16 and PE_COLS = 16.
REQ-032 SHALL use a sub-module requant_sat: one combinational lane (round, shift, ReLU, saturate), parameterized by OUTPUT_WIDTH and ACT_WIDTH, instantiated 16 times.

Verification
REQ-033 Basic drain: capture with pe_outs[r][c] = r*16+c, shift = 0, relu_en = 0, out_ready = 1 -> 16 consecutive beats, rows 0..15. Beat r lane c = min(r*16+c, 127). out_last only on beat 15, then out_valid = 0.
REQ-034 Rounding and saturation: values {5, 6, -6, 100000, -100000}, shift = 2 -> {1, 2, -1, 127, -128}.
REQ-035 ReLU: values {-1, -300, 0, 50}, relu_en = 1, shift = 0 -> {0, 0, 0, 50}.
REQ-036 Backpressure: toggle out_ready 1,0,0,1 during the drain -> beats hold stable while ready is low; exactly 16 beats, no row duplicated or skipped. capture_valid pulsed mid-drain is ignored (capture_ready = 0).
REQ-037 Reset mid-drain: assert arst_n_in at row 7 -> out_valid = 0 immediately, capture_ready = 1. A new capture restarts from row 0 with the new data.
